// File: rtl/multicycle_controller_if.sv
// Handshake and strobe bundle between the multi-cycle sequencer and the core datapath/memories.
interface multicycle_controller_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      ir;
  logic             alu_zero;
  logic             imem_ready;
  logic             dmem_ready;
  logic             resume;
  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             ir_write;
  logic             reg_write;
  logic             alu_src;
  logic             ext_op;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             halted;
  logic [1:0]       err_code;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired_count;

  modport master (
    input  ir, alu_zero, imem_ready, dmem_ready, resume,
    output imem_req, dmem_req, dmem_we, ir_write, reg_write, alu_src, ext_op,
           pc_write, pc_src, halted, err_code, state, retired_count
  );

  modport slave (
    output ir, alu_zero, imem_ready, dmem_ready, resume,
    input  imem_req, dmem_req, dmem_we, ir_write, reg_write, alu_src, ext_op,
           pc_write, pc_src, halted, err_code, state, retired_count
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: memory handshakes with timeout,
// halt on stop bit / illegal opcode / timeout, and a retired-instruction counter.
module multicycle_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_STOP = 2'b01;
  localparam logic [1:0] ERR_ILL  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [1:0]        err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  // Instruction field decode from the latched IR
  logic       stop_c;
  logic [1:0] typ_c;
  logic [4:0] op_c;
  logic       is_r_c, is_j_c, is_i_c, is_s_c;
  logic       legal_c, is_lw_c, is_sw_c, is_beq_c, is_jmp_c, is_andi_c;
  logic       retire_c;
  logic       unused_ir_c;

  assign stop_c      = bus.ir[31];
  assign typ_c       = bus.ir[30:29];
  assign op_c        = bus.ir[4:0];
  assign unused_ir_c = ^bus.ir[28:5];

  assign is_r_c    = (typ_c == 2'b00);
  assign is_j_c    = (typ_c == 2'b01);
  assign is_i_c    = (typ_c == 2'b10);
  assign is_s_c    = (typ_c == 2'b11);
  assign is_andi_c = is_i_c && (op_c == 5'd0);
  assign is_lw_c   = is_i_c && (op_c == 5'd2);
  assign is_sw_c   = is_i_c && (op_c == 5'd3);
  assign is_beq_c  = is_i_c && (op_c == 5'd4);
  assign is_jmp_c  = is_j_c && (op_c == 5'd0);
  assign legal_c   = (is_r_c && (op_c < 5'd4)) || is_jmp_c ||
                     (is_i_c && (op_c < 5'd5)) || (is_s_c && (op_c < 5'd4));

  assign retire_c = ((state_q == S_EXEC) && (is_jmp_c || is_beq_c)) ||
                    ((state_q == S_MEM) && bus.dmem_ready && is_sw_c) ||
                    (state_q == S_WB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      err_q   <= ERR_NONE;
      cnt_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    if (retire_c) begin
      cnt_d = cnt_q + CNT_W'(1);
      // A retiring instruction with the stop bit parks the core instead of fetching
      state_d = stop_c ? S_HALT : S_FETCH;
      if (stop_c) err_d = ERR_STOP;
    end
    unique case (state_q)
      S_FETCH: begin
        if (bus.imem_ready) begin
          wait_d  = '0;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = S_HALT;
          err_d   = ERR_TMO;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (legal_c) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
          err_d   = ERR_ILL;
        end
      end
      S_EXEC: begin
        if (is_lw_c || is_sw_c)              state_d = S_MEM;
        else if (!(is_jmp_c || is_beq_c))    state_d = S_WB;
      end
      S_MEM: begin
        if (bus.dmem_ready) begin
          wait_d = '0;
          if (is_lw_c) state_d = S_WB;
        end else if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = S_HALT;
          err_d   = ERR_TMO;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: ;
      S_HALT: begin
        wait_d = '0;
        // Only a stop-bit halt is recoverable; fault halts stay until reset
        if (bus.resume && (err_q == ERR_STOP)) begin
          state_d = S_FETCH;
          err_d   = ERR_NONE;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    bus.imem_req  = 1'b0;
    bus.dmem_req  = 1'b0;
    bus.dmem_we   = 1'b0;
    bus.ir_write  = 1'b0;
    bus.reg_write = 1'b0;
    bus.alu_src   = 1'b0;
    bus.ext_op    = 1'b0;
    bus.pc_write  = 1'b0;
    bus.pc_src    = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        bus.ir_write = bus.imem_ready;
      end
      S_EXEC: begin
        bus.alu_src = is_i_c;
        bus.ext_op  = !is_andi_c;
        if (is_jmp_c) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = 2'b10;
        end else if (is_beq_c) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = bus.alu_zero ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = is_sw_c;
        bus.alu_src  = 1'b1;
        bus.ext_op   = 1'b1;
        bus.pc_write = bus.dmem_ready && is_sw_c;
      end
      S_WB: begin
        bus.reg_write = 1'b1;
        bus.pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.halted        = (state_q == S_HALT);
  assign bus.err_code      = err_q;
  assign bus.state         = state_q;
  assign bus.retired_count = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller with hand-computed expectations.
module tb_multicycle_controller;

  localparam logic [31:0] I_ADD     = 32'h0000_0000;
  localparam logic [31:0] I_LW      = 32'h4000_0002;
  localparam logic [31:0] I_SW      = 32'h4000_0003;
  localparam logic [31:0] I_SW_STOP = 32'hC000_0003;
  localparam logic [31:0] I_BEQ     = 32'h4000_0004;
  localparam logic [31:0] I_JMP     = 32'h2000_0000;
  localparam logic [31:0] I_ANDI    = 32'h4000_0000;
  localparam logic [31:0] I_SLL     = 32'h6000_0002;
  localparam logic [31:0] I_ILL     = 32'h0000_0007;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_controller_if #(.CNT_W(32)) bus ();

  multicycle_controller #(.TIMEOUT_CYCLES(15), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  int         r_lat, r_dreq, r_we, r_pcw, r_rw, r_rw_out;
  logic [1:0] r_psrc;
  logic       r_ext, r_src;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.resume     = 1'b0;
    bus.alu_zero   = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Runs one instruction from FETCH until the FSM returns to FETCH or HALT; dlat is the MEM cycle with dmem_ready
  task automatic run_instr(input logic [31:0] iv, input int dlat);
    int mc;
    mc = 0;
    bus.ir = iv;
    bus.imem_ready = 1'b1;
    r_lat = 0; r_dreq = 0; r_we = 0; r_pcw = 0; r_rw = 0; r_rw_out = 0;
    r_psrc = 2'b11; r_ext = 1'bx; r_src = 1'bx;
    for (int c = 0; c < 40; c++) begin
      if (bus.state == 3'd3) begin
        mc++;
        bus.dmem_ready = (mc >= dlat);
      end else begin
        bus.dmem_ready = 1'b0;
      end
      #1;
      r_dreq += int'(bus.dmem_req);
      r_we   += int'(bus.dmem_we);
      if (bus.pc_write) begin
        r_pcw++;
        r_psrc = bus.pc_src;
      end
      if (bus.reg_write) begin
        r_rw++;
        if (bus.state != 3'd4) r_rw_out++;
      end
      if (bus.state == 3'd2) begin
        r_ext = bus.ext_op;
        r_src = bus.alu_src;
      end
      step();
      r_lat++;
      if (bus.state == 3'd0 || bus.state == 3'd5) break;
    end
    bus.dmem_ready = 1'b0;
  endtask

  initial begin
    int n;
    bus.ir = '0;
    do_reset();

    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_err", 32'(bus.err_code), 32'd0);
    chk("rst_cnt", bus.retired_count, 32'd0);
    chk("rst_strobes", 32'({bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_write, bus.reg_write,
                            bus.alu_src, bus.ext_op, bus.pc_write, bus.halted}), 32'b1_0000_0000);
    bus.imem_ready = 1'b1;
    #1;
    chk("fetch_ir_write", 32'(bus.ir_write), 32'd1);

    run_instr(I_ADD, 1);
    chk("add_lat", r_lat, 4);
    chk("add_rw", r_rw, 1);
    chk("add_rw_outside_wb", r_rw_out, 0);
    chk("add_pc", 32'({r_pcw[1:0], r_psrc}), 32'b01_00);
    chk("add_cnt", bus.retired_count, 32'd1);
    chk("add_state", 32'(bus.state), 32'd0);

    run_instr(I_LW, 3);
    chk("lw_lat", r_lat, 7);
    chk("lw_dreq", r_dreq, 3);
    chk("lw_we", r_we, 0);
    chk("lw_rw", r_rw, 1);
    chk("lw_exec_src", 32'(r_src), 32'd1);
    chk("lw_cnt", bus.retired_count, 32'd2);

    run_instr(I_SW, 1);
    chk("sw_lat", r_lat, 4);
    chk("sw_we", r_we, 1);
    chk("sw_rw", r_rw, 0);
    chk("sw_pcw", r_pcw, 1);
    chk("sw_cnt", bus.retired_count, 32'd3);

    bus.alu_zero = 1'b1;
    run_instr(I_BEQ, 1);
    chk("beq_t_lat", r_lat, 3);
    chk("beq_t_pc", 32'({r_pcw[1:0], r_psrc}), 32'b01_01);
    bus.alu_zero = 1'b0;
    run_instr(I_BEQ, 1);
    chk("beq_nt_pc", 32'({r_pcw[1:0], r_psrc}), 32'b01_00);
    chk("beq_cnt", bus.retired_count, 32'd5);

    run_instr(I_JMP, 1);
    chk("jmp_lat", r_lat, 3);
    chk("jmp_pc", 32'({r_pcw[1:0], r_psrc}), 32'b01_10);

    run_instr(I_ANDI, 1);
    chk("andi_lat", r_lat, 4);
    chk("andi_ext_src", 32'({r_ext, r_src}), 32'b01);
    run_instr(I_SLL, 1);
    chk("sll_ext_src", 32'({r_ext, r_src}), 32'b10);
    chk("alu_cnt", bus.retired_count, 32'd8);

    // Stop-bit halt and resume
    do_reset();
    run_instr(I_SW_STOP, 1);
    chk("stop_lat", r_lat, 4);
    chk("stop_state", 32'(bus.state), 32'd5);
    chk("stop_err", 32'(bus.err_code), 32'd1);
    chk("stop_cnt", bus.retired_count, 32'd1);
    chk("halt_strobes", 32'({bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_write, bus.reg_write,
                             bus.alu_src, bus.ext_op, bus.pc_write, bus.halted}), 32'b0_0000_0001);
    bus.resume = 1'b1;
    step();
    bus.resume = 1'b0;
    chk("resume_state", 32'(bus.state), 32'd0);
    chk("resume_err", 32'(bus.err_code), 32'd0);
    chk("resume_cnt", bus.retired_count, 32'd1);

    // Illegal opcode is sticky
    run_instr(I_ILL, 1);
    chk("ill_lat", r_lat, 2);
    chk("ill_pcw", r_pcw, 0);
    chk("ill_state_err", 32'({bus.state, bus.err_code}), 32'b101_10);
    chk("ill_cnt", bus.retired_count, 32'd1);
    bus.resume = 1'b1;
    step();
    bus.resume = 1'b0;
    chk("ill_resume_ignored", 32'({bus.state, bus.err_code}), 32'b101_10);

    // Fetch timeout after exactly 15 waiting cycles
    do_reset();
    n = 0;
    while (bus.state == 3'd0 && n < 40) begin
      step();
      n++;
    end
    chk("tmo_cycles", n, 15);
    chk("tmo_state_err", 32'({bus.state, bus.err_code}), 32'b101_11);
    bus.resume = 1'b1;
    step();
    bus.resume = 1'b0;
    chk("tmo_resume_ignored", 32'({bus.state, bus.err_code}), 32'b101_11);

    // Ready in the final wait cycle still wins
    do_reset();
    bus.ir = I_ADD;
    for (int i = 0; i < 14; i++) step();
    chk("tmo_edge_fetch", 32'(bus.state), 32'd0);
    bus.imem_ready = 1'b1;
    step();
    chk("tmo_edge_decode", 32'({bus.state, bus.err_code}), 32'b001_00);

    // Asynchronous reset during a data access
    do_reset();
    run_instr(I_ADD, 1);
    bus.ir = I_LW;
    step();
    step();
    step();
    chk("mem_before_rst", 32'({bus.state, bus.dmem_req}), 32'b011_1);
    rst = 1'b1;
    #1;
    chk("mem_async_rst", 32'({bus.state, bus.dmem_req, bus.imem_req}), 32'b000_0_1);
    chk("mem_rst_cnt", bus.retired_count, 32'd0);
    step();
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
